// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one byte/half/word request at a time onto a word-wide data memory.
// Latency accept->resp: error 1, load 2, SW 2, SB/SH 3 cycles (read-modify-write).
// Backpressure: o_req_ready only in IDLE; the response is a single-cycle pulse with no stall.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_wEn,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_dataWrite,
    input  logic [31:0] i_mem_dataRead
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdword;

    logic        w_accept;
    logic        w_bad_f3;
    logic        w_misalign;
    logic        w_range;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_accept = i_req_valid && (r_state == ST_IDLE);

    // Request legality, judged on the live inputs in the accept cycle
    always_comb begin
        w_bad_f3   = 1'b0;
        w_misalign = 1'b0;
        if (i_req_store) begin
            w_bad_f3 = (i_req_funct3 != 3'b000) && (i_req_funct3 != 3'b001) &&
                       (i_req_funct3 != 3'b010);
        end else begin
            w_bad_f3 = (i_req_funct3 != 3'b000) && (i_req_funct3 != 3'b001) &&
                       (i_req_funct3 != 3'b010) && (i_req_funct3 != 3'b100) &&
                       (i_req_funct3 != 3'b101);
        end
        // funct3[1:0] encodes size for both loads and stores: 01 half, 10 word
        if (i_req_funct3[1:0] == 2'b01) begin
            w_misalign = i_req_addr[0];
        end else if (i_req_funct3[1:0] == 2'b10) begin
            w_misalign = |i_req_addr[1:0];
        end
        w_range = (i_req_addr[31:2] >= LP_WORDS);
        w_err   = w_bad_f3 || w_misalign || w_range;
    end

    // State register; reset drops any in-flight request, including a pending write
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next = ST_RESP;
                    end else if (i_req_store && (i_req_funct3[1:0] == 2'b10)) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD:   w_next = r_store ? ST_WR : ST_RESP;
            ST_WR:   w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latches, captured only on accept so later input changes are ignored
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_store  <= i_req_store;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_err    <= w_err;
        end
    end

    // Read word captured in RD; feeds load extraction and sub-word merge
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rdword <= 32'h0;
        end else if (r_state == ST_RD) begin
            r_rdword <= i_mem_dataRead;
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        w_byte = r_rdword[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = r_rdword[7:0];
            2'd1: w_byte = r_rdword[15:8];
            2'd2: w_byte = r_rdword[23:16];
            2'd3: w_byte = r_rdword[31:24];
            default: w_byte = r_rdword[7:0];
        endcase
        w_half = r_addr[1] ? r_rdword[31:16] : r_rdword[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = r_rdword;
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = 32'h0;
        endcase
    end

    // Store word: full word for SW, otherwise splice new lane into the read word
    always_comb begin
        w_merge = r_rdword;
        case (r_funct3[1:0])
            2'b00: begin
                case (r_addr[1:0])
                    2'd0: w_merge[7:0]   = r_wdata[7:0];
                    2'd1: w_merge[15:8]  = r_wdata[7:0];
                    2'd2: w_merge[23:16] = r_wdata[7:0];
                    2'd3: w_merge[31:24] = r_wdata[7:0];
                    default: w_merge = r_rdword;
                endcase
            end
            2'b01: begin
                if (r_addr[1]) begin
                    w_merge[31:16] = r_wdata[15:0];
                end else begin
                    w_merge[15:0] = r_wdata[15:0];
                end
            end
            default: w_merge = r_wdata;
        endcase
    end

    // Outputs decoded from state so reset clears them (and mem_wEn) immediately
    always_comb begin
        o_req_ready     = (r_state == ST_IDLE);
        o_resp_valid    = (r_state == ST_RESP);
        o_resp_err      = (r_state == ST_RESP) && r_err;
        o_resp_rdata    = 32'h0;
        o_mem_wEn       = (r_state == ST_WR);
        o_mem_address   = 32'h0;
        o_mem_dataWrite = 32'h0;
        if ((r_state == ST_RESP) && !r_err && !r_store) begin
            o_resp_rdata = w_load;
        end
        if ((r_state == ST_RD) || (r_state == ST_WR)) begin
            o_mem_address = {2'b00, r_addr[31:2]};
        end
        if (r_state == ST_WR) begin
            o_mem_dataWrite = w_merge;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory.
// Latency measured in clocks from the accept edge to the first visible resp_valid.
// Requests are issued one at a time; the bench never stalls responses.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wen;
    logic [31:0] mem_address;
    logic [31:0] mem_data_wr;
    logic [31:0] mem_data_rd;

    logic [31:0] mem [0:1023];
    int          wen_cnt;
    int          resp_cnt;
    int          checks;
    int          failures;

    lsu_mem_ctrl #(.MEM_WORDS(1024)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_store     (req_store),
        .i_req_funct3    (req_funct3),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_resp_valid    (resp_valid),
        .o_resp_rdata    (resp_rdata),
        .o_resp_err      (resp_err),
        .o_mem_wEn       (mem_wen),
        .o_mem_address   (mem_address),
        .o_mem_dataWrite (mem_data_wr),
        .i_mem_dataRead  (mem_data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_rd = mem[mem_address[9:0]];

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_address[9:0]] <= mem_data_wr;
            wen_cnt <= wen_cnt + 1;
        end
        if (resp_valid) begin
            resp_cnt <= resp_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then scramble the inputs to show they are ignored mid-operation
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic er);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = ~st;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5A5A_5A5A;
        lat = -1;
        rd  = 32'hXXXX_XXXX;
        er  = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w0;
    int          r0;

    initial begin
        checks    = 0;
        failures  = 0;
        wen_cnt   = 0;
        resp_cnt  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        chk("rst_wen", {31'h0, mem_wen}, 32'h0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_data_wr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Loads with sign/zero extension
        mem[3] = 32'h8000_00F0;
        do_req(1'b0, 3'b000, 32'h0C, 32'h0, lat, rd, er);
        chk("lb_lat", lat, 2);
        chk("lb_data", rd, 32'hFFFF_FFF0);
        chk("lb_err", {31'h0, er}, 32'h0);
        chk("after_resp_ready", {31'h0, req_ready}, 32'h1);
        chk("after_resp_valid", {31'h0, resp_valid}, 32'h0);
        do_req(1'b0, 3'b100, 32'h0F, 32'h0, lat, rd, er);
        chk("lbu_data", rd, 32'h0000_0080);
        do_req(1'b0, 3'b101, 32'h0E, 32'h0, lat, rd, er);
        chk("lhu_data", rd, 32'h0000_8000);
        do_req(1'b0, 3'b001, 32'h0E, 32'h0, lat, rd, er);
        chk("lh_data", rd, 32'hFFFF_8000);
        chk("lh_lat", lat, 2);
        do_req(1'b0, 3'b001, 32'h0C, 32'h0, lat, rd, er);
        chk("lh_lo_data", rd, 32'h0000_00F0);

        // Sub-word stores (read-modify-write)
        mem[3] = 32'h1122_3344;
        w0 = wen_cnt;
        do_req(1'b1, 3'b000, 32'h0D, 32'h0000_00AB, lat, rd, er);
        chk("sb_lat", lat, 3);
        chk("sb_mem", mem[3], 32'h1122_AB44);
        chk("sb_wen_cnt", wen_cnt - w0, 1);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_err", {31'h0, er}, 32'h0);
        do_req(1'b1, 3'b001, 32'h0E, 32'h1234_5678, lat, rd, er);
        chk("sh_mem", mem[3], 32'h5678_AB44);
        chk("sh_lat", lat, 3);

        // Word store/load and misaligned half
        w0 = wen_cnt;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        chk("sw_lat", lat, 2);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        chk("sw_wen_cnt", wen_cnt - w0, 1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
        chk("lw_data", rd, 32'hDEAD_BEEF);
        w0 = wen_cnt;
        do_req(1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF, lat, rd, er);
        chk("sh_mis_err", {31'h0, er}, 32'h1);
        chk("sh_mis_lat", lat, 1);
        chk("sh_mis_nowr", wen_cnt - w0, 0);
        chk("sh_mis_mem", mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, lat, rd, er);
        chk("lw_mis_err", {31'h0, er}, 32'h1);
        chk("lw_mis_rdata", rd, 32'h0);

        // Range and illegal funct3
        w0 = wen_cnt;
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, rd, er);
        chk("lw_oor_err", {31'h0, er}, 32'h1);
        chk("lw_oor_lat", lat, 1);
        do_req(1'b1, 3'b010, 32'h1000, 32'h1, lat, rd, er);
        chk("sw_oor_err", {31'h0, er}, 32'h1);
        chk("oor_nowr", wen_cnt - w0, 0);
        mem[1023] = 32'hCAFE_F00D;
        do_req(1'b0, 3'b010, 32'h0FFC, 32'h0, lat, rd, er);
        chk("lw_last_err", {31'h0, er}, 32'h0);
        chk("lw_last_data", rd, 32'hCAFE_F00D);
        do_req(1'b0, 3'b011, 32'h0, 32'h0, lat, rd, er);
        chk("f3_011_err", {31'h0, er}, 32'h1);
        do_req(1'b1, 3'b100, 32'h0, 32'h0, lat, rd, er);
        chk("sf3_100_err", {31'h0, er}, 32'h1);

        // Reset during the write cycle of an SB
        mem[5] = 32'hAABB_CCDD;
        w0 = wen_cnt;
        r0 = resp_cnt;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h14;
        req_wdata  = 32'h11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstwr_wen_hi", {31'h0, mem_wen}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rstwr_wen_lo", {31'h0, mem_wen}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstwr_mem", mem[5], 32'hAABB_CCDD);
        chk("rstwr_nowr", wen_cnt - w0, 0);
        chk("rstwr_noresp", resp_cnt - r0, 0);
        chk("rstwr_ready", {31'h0, req_ready}, 32'h1);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, lat, rd, er);
        chk("rstwr_readback", rd, 32'hAABB_CCDD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
